// File: rtl/mandel_pixel_collector_if.sv
// Frame-buffer write port of the Mandelbrot pixel collector: valid/ready with
// a linear pixel address and an 8-bit colour index.
interface mandel_pixel_collector_if #(
    parameter int ADDR_W = 17
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/mandel_pixel_collector.sv
// Collects escape results from the Mandelbrot pipeline tail and writes colour indices to the
// frame buffer through a first-word-fall-through FIFO. Optional ESCAPE_COUNT_EN adds escape_count.
module mandel_pixel_collector #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [7:0]             in_div,
    input  logic                   in_no_op,
    mandel_pixel_collector_if.master wr,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow
`ifdef ESCAPE_COUNT_EN
    ,
    output logic [ADDR_W-1:0]      escape_count
`endif
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
`ifdef ESCAPE_COUNT_EN
    logic [ADDR_W-1:0] esc_q, esc_d;
`endif

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [7:0]        mem_data [FIFO_DEPTH];

    logic empty, full, pop, pix, push, drop, last_pix;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop      = !empty && wr.wr_ready;
    assign pix      = (state_q == S_RUN) && in_valid;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push     = pix && (!full || pop);
    assign drop     = pix && full && !pop;
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        overflow_d = overflow_q;
`ifdef ESCAPE_COUNT_EN
        esc_d      = esc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    x_d        = '0;
                    y_d        = '0;
                    addr_d     = '0;
                    overflow_d = 1'b0;
`ifdef ESCAPE_COUNT_EN
                    esc_d      = '0;
`endif
                end
            end
            S_RUN: begin
                if (pix) begin
                    // Raster position advances whether or not the pixel fits in the FIFO.
                    addr_d = addr_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (last_pix) state_d = S_DRAIN;
                    if (drop) overflow_d = 1'b1;
`ifdef ESCAPE_COUNT_EN
                    if (in_no_op) esc_d = esc_q + 1'b1;
`endif
                end
            end
            S_DRAIN: begin
                if (empty) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_ptr_d = wr_ptr_q + (PW + 1)'(push);
    assign rd_ptr_d = rd_ptr_q + (PW + 1)'(pop);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
`ifdef ESCAPE_COUNT_EN
            esc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
`ifdef ESCAPE_COUNT_EN
            esc_q      <= esc_d;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_addr[wr_ptr_q[PW-1:0]] <= addr_q;
            mem_data[wr_ptr_q[PW-1:0]] <= in_no_op ? in_div : 8'h00;
        end
    end

    // Storage is not reset, so the head is masked to zero while the FIFO is empty.
    assign wr.wr_valid = !empty;
    assign wr.wr_addr  = empty ? '0 : mem_addr[rd_ptr_q[PW-1:0]];
    assign wr.wr_data  = empty ? 8'h00 : mem_data[rd_ptr_q[PW-1:0]];

    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign frame_done = (state_q == S_DONE);
    assign overflow   = overflow_q;
`ifdef ESCAPE_COUNT_EN
    assign escape_count = esc_q;
`endif
endmodule
